// File: rtl/arcade_input_pkg.sv
// Shared types, joystick bit layout and the default PS/2 keymap for the arcade input front end.
package arcade_input_pkg;

    localparam int MAX_PLAYERS = 2;
    localparam int JOY_W       = 16;

    localparam int JOY_RIGHT = 0;
    localparam int JOY_LEFT  = 1;
    localparam int JOY_DOWN  = 2;
    localparam int JOY_UP    = 3;
    localparam int JOY_BTN0  = 4;

    typedef enum logic [1:0] {
        SRC_USB      = 2'd0,
        SRC_DB15_P1  = 2'd1,
        SRC_DB15_ALL = 2'd2,
        SRC_OR       = 2'd3
    } src_sel_e;

    typedef enum logic [1:0] {
        SOCD_PASS    = 2'd0,
        SOCD_NEUTRAL = 2'd1,
        SOCD_LAST    = 2'd2,
        SOCD_RSVD    = 2'd3
    } socd_mode_e;

    typedef enum logic [1:0] {
        KF_DIR   = 2'd0,
        KF_BTN   = 2'd1,
        KF_START = 2'd2,
        KF_COIN  = 2'd3
    } key_field_e;

    typedef struct packed {
        logic       ext;
        logic [7:0] code;
        logic       player;
        key_field_e field;
        logic [1:0] index;
    } key_entry_t;

    localparam int NUM_KEYS = 20;

    // Direction index follows the joystick bit layout: 3 up, 2 down, 1 left, 0 right.
    localparam key_entry_t KEYMAP [NUM_KEYS] = '{
        '{1'b1, 8'h75, 1'b0, KF_DIR,   2'd3},
        '{1'b1, 8'h72, 1'b0, KF_DIR,   2'd2},
        '{1'b1, 8'h6B, 1'b0, KF_DIR,   2'd1},
        '{1'b1, 8'h74, 1'b0, KF_DIR,   2'd0},
        '{1'b0, 8'h14, 1'b0, KF_BTN,   2'd0},
        '{1'b0, 8'h11, 1'b0, KF_BTN,   2'd1},
        '{1'b0, 8'h29, 1'b0, KF_BTN,   2'd2},
        '{1'b0, 8'h12, 1'b0, KF_BTN,   2'd3},
        '{1'b0, 8'h16, 1'b0, KF_START, 2'd0},
        '{1'b0, 8'h2E, 1'b0, KF_COIN,  2'd0},
        '{1'b0, 8'h2D, 1'b1, KF_DIR,   2'd3},
        '{1'b0, 8'h2B, 1'b1, KF_DIR,   2'd2},
        '{1'b0, 8'h23, 1'b1, KF_DIR,   2'd1},
        '{1'b0, 8'h34, 1'b1, KF_DIR,   2'd0},
        '{1'b0, 8'h1C, 1'b1, KF_BTN,   2'd0},
        '{1'b0, 8'h1B, 1'b1, KF_BTN,   2'd1},
        '{1'b0, 8'h15, 1'b1, KF_BTN,   2'd2},
        '{1'b0, 8'h1D, 1'b1, KF_BTN,   2'd3},
        '{1'b0, 8'h1E, 1'b1, KF_START, 2'd0},
        '{1'b0, 8'h36, 1'b1, KF_COIN,  2'd0}
    };

    function automatic logic [3:0] key_bit(input key_entry_t e, input int start_bit, input int coin_bit);
        logic [3:0] b;
        case (e.field)
            KF_DIR:   b = {2'b00, e.index};
            KF_BTN:   b = 4'(JOY_BTN0) + {2'b00, e.index};
            KF_START: b = 4'(start_bit);
            default:  b = 4'(coin_bit);
        endcase
        return b;
    endfunction

endpackage

// File: rtl/arcade_input_mapper_coin.sv
// Coin pulse stretcher: one fixed-length pulse per fresh coin press, re-armed only after coin is seen low.
module coin_stretcher #(
    parameter int COIN_PULSE = 4_800_000
) (
    input  logic clk,
    input  logic reset,
    input  logic coin_raw,
    output logic coin_out
);

    localparam int CW = $clog2(COIN_PULSE + 1);

    logic [CW-1:0] cnt;
    logic          armed;
    logic          prev;
    logic          idle;
    logic          fire;

    assign idle = (cnt == '0);
    assign fire = armed & coin_raw & ~prev & idle;

    // prev is loaded even during reset so a coin held through reset never counts as an edge.
    always_ff @(posedge clk) begin
        prev <= coin_raw;
        if (reset) begin
            cnt      <= '0;
            armed    <= 1'b1;
            coin_out <= 1'b0;
        end else if (fire) begin
            cnt      <= CW'(COIN_PULSE);
            armed    <= 1'b0;
            coin_out <= 1'b1;
        end else begin
            if (!idle)
                cnt <= cnt - 1'b1;
            coin_out <= (cnt > CW'(1));
            if (idle && !coin_raw)
                armed <= 1'b1;
        end
    end

endmodule

// File: rtl/arcade_input_mapper.sv
// Merges PS/2 keys, USB and DB15 joysticks into per-player direction/button/start/coin outputs
// with SOCD cleaning, per-button autofire and coin stretching.
module arcade_input_mapper
    import arcade_input_pkg::*;
#(
    parameter int NUM_PLAYERS  = 2,
    parameter int NUM_BUTTONS  = 2,
    parameter int START_BIT    = 6,
    parameter int COIN_BIT     = 8,
    parameter int COIN_PULSE   = 4_800_000,
    parameter int AUTOFIRE_DIV = 2_400_000
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [10:0]                    ps2_key,
    input  logic [NUM_PLAYERS*JOY_W-1:0]   joy_usb,
    input  logic [NUM_PLAYERS*JOY_W-1:0]   joy_db15,
    input  logic [1:0]                     src_sel,
    input  logic [1:0]                     socd_mode,
    input  logic [NUM_BUTTONS-1:0]         autofire_en,
    output logic [NUM_PLAYERS*4-1:0]       dir,
    output logic [NUM_PLAYERS*NUM_BUTTONS-1:0] btn,
    output logic [NUM_PLAYERS-1:0]         start,
    output logic [NUM_PLAYERS-1:0]         coin
);

    localparam int AF_W = (AUTOFIRE_DIV > 1) ? $clog2(AUTOFIRE_DIV) : 1;

    logic                                  toggle_q;
    logic [NUM_KEYS-1:0]                   held;
    logic [MAX_PLAYERS-1:0][JOY_W-1:0]     kb_vec;
    logic [NUM_PLAYERS-1:0][JOY_W-1:0]     raw;
    logic [NUM_PLAYERS*4-1:0]              dir_next;
    logic [AF_W-1:0]                       af_cnt;
    logic                                  phase;

    // Extended flag is part of the match, so E0-14 never aliases plain 14.
    always_ff @(posedge clk) begin
        toggle_q <= ps2_key[10];
        if (reset) begin
            held <= '0;
        end else if (ps2_key[10] != toggle_q) begin
            for (int k = 0; k < NUM_KEYS; k++)
                if (KEYMAP[k].ext == ps2_key[8] && KEYMAP[k].code == ps2_key[7:0])
                    held[k] <= ps2_key[9];
        end
    end

    always_comb begin
        kb_vec = '0;
        for (int k = 0; k < NUM_KEYS; k++)
            if (held[k] && (KEYMAP[k].field != KF_BTN || int'(KEYMAP[k].index) < NUM_BUTTONS))
                kb_vec[KEYMAP[k].player][key_bit(KEYMAP[k], START_BIT, COIN_BIT)] = 1'b1;
    end

    always_comb begin
        raw = '0;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            case (src_sel_e'(src_sel))
                SRC_USB:      raw[p] = joy_usb[p*JOY_W +: JOY_W];
                SRC_DB15_P1:  raw[p] = (p == 0) ? joy_db15[JOY_W-1:0] : joy_usb[JOY_W-1:0];
                SRC_DB15_ALL: raw[p] = joy_db15[p*JOY_W +: JOY_W];
                default:      raw[p] = joy_usb[p*JOY_W +: JOY_W] | joy_db15[p*JOY_W +: JOY_W];
            endcase
            raw[p] = raw[p] | kb_vec[p];
        end
    end

    // Axis 0 is right(lo)/left(hi), axis 1 is down(lo)/up(hi); last=1 means the hi side won.
    for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
        for (genvar a = 0; a < 2; a++) begin : g_axis
            localparam int LO = 2 * a;
            localparam int HI = 2 * a + 1;

            logic       prev_lo, prev_hi, last, tie;
            logic       lo_in, hi_in, rise_lo, rise_hi, last_next, tie_next;
            logic [1:0] axis_out;

            assign lo_in     = raw[p][LO];
            assign hi_in     = raw[p][HI];
            assign rise_lo   = lo_in & ~prev_lo;
            assign rise_hi   = hi_in & ~prev_hi;
            assign last_next = (rise_hi & ~rise_lo) ? 1'b1 :
                               (rise_lo & ~rise_hi) ? 1'b0 : last;
            assign tie_next  = (rise_lo & rise_hi) | (tie & lo_in & hi_in);

            always_ff @(posedge clk) begin
                if (reset) begin
                    prev_lo <= 1'b0;
                    prev_hi <= 1'b0;
                    last    <= 1'b0;
                    tie     <= 1'b0;
                end else begin
                    prev_lo <= lo_in;
                    prev_hi <= hi_in;
                    last    <= last_next;
                    tie     <= tie_next;
                end
            end

            always_comb begin
                axis_out = {hi_in, lo_in};
                if (lo_in && hi_in) begin
                    case (socd_mode_e'(socd_mode))
                        SOCD_NEUTRAL: axis_out = 2'b00;
                        SOCD_LAST:    axis_out = tie_next ? 2'b00 : (last_next ? 2'b10 : 2'b01);
                        default:      axis_out = 2'b11;
                    endcase
                end
            end

            assign dir_next[p*4 + LO] = axis_out[0];
            assign dir_next[p*4 + HI] = axis_out[1];
        end
    end

    // Autofire gating uses the phase value from before this edge's wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            dir    <= '0;
            btn    <= '0;
            start  <= '0;
            af_cnt <= '0;
            phase  <= 1'b0;
        end else begin
            dir <= dir_next;
            if (af_cnt == AF_W'(AUTOFIRE_DIV - 1)) begin
                af_cnt <= '0;
                phase  <= ~phase;
            end else begin
                af_cnt <= af_cnt + 1'b1;
            end
            for (int p = 0; p < NUM_PLAYERS; p++) begin
                for (int b = 0; b < NUM_BUTTONS; b++)
                    btn[p*NUM_BUTTONS + b] <= raw[p][JOY_BTN0 + b] & (~autofire_en[b] | phase);
                start[p] <= raw[p][START_BIT];
            end
        end
    end

    for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_coin
        coin_stretcher #(
            .COIN_PULSE(COIN_PULSE)
        ) u_coin (
            .clk     (clk),
            .reset   (reset),
            .coin_raw(raw[p][COIN_BIT]),
            .coin_out(coin[p])
        );
    end

endmodule

// File: tb/tb_arcade_input_mapper.sv
// Directed self-checking bench for arcade_input_mapper (2 players, 2 buttons, short coin/autofire).
module tb_arcade_input_mapper;

    logic        clk = 1'b0;
    logic        reset;
    logic [10:0] ps2_key;
    logic [31:0] joy_usb;
    logic [31:0] joy_db15;
    logic [1:0]  src_sel;
    logic [1:0]  socd_mode;
    logic [1:0]  autofire_en;
    logic [7:0]  dir;
    logic [3:0]  btn;
    logic [1:0]  start;
    logic [1:0]  coin;

    int checks = 0;
    int fails  = 0;
    logic tog;

    arcade_input_mapper #(
        .NUM_PLAYERS (2),
        .NUM_BUTTONS (2),
        .START_BIT   (6),
        .COIN_BIT    (8),
        .COIN_PULSE  (10),
        .AUTOFIRE_DIV(4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .ps2_key    (ps2_key),
        .joy_usb    (joy_usb),
        .joy_db15   (joy_db15),
        .src_sel    (src_sel),
        .socd_mode  (socd_mode),
        .autofire_en(autofire_en),
        .dir        (dir),
        .btn        (btn),
        .start      (start),
        .coin       (coin)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic ps2_event(input logic pressed, input logic ext, input logic [7:0] code);
        tog     = ~tog;
        ps2_key = {tog, pressed, ext, code};
    endtask

    task automatic test_reset;
        tog         = 1'b1;
        ps2_key     = {1'b1, 1'b1, 1'b1, 8'h74};
        joy_usb     = '0;
        joy_db15    = '0;
        src_sel     = 2'd0;
        socd_mode   = 2'd0;
        autofire_en = 2'b00;
        reset       = 1'b1;
        step(2);
        checks++; if (dir !== 8'h00)  begin fails++; $display("[TB] FAIL reset_dir: got %h expected 00", dir); end
        checks++; if (btn !== 4'h0)   begin fails++; $display("[TB] FAIL reset_btn: got %h expected 0", btn); end
        checks++; if (start !== 2'b0) begin fails++; $display("[TB] FAIL reset_start: got %b expected 00", start); end
        checks++; if (coin !== 2'b0)  begin fails++; $display("[TB] FAIL reset_coin: got %b expected 00", coin); end
        reset = 1'b0;
        step(3);
        checks++; if (dir !== 8'h00)  begin fails++; $display("[TB] FAIL no_event_after_reset: got dir %h expected 00", dir); end
        checks++; if (btn !== 4'h0 || start !== 2'b0 || coin !== 2'b0)
            begin fails++; $display("[TB] FAIL post_reset_idle: got btn %h start %b coin %b expected zeros", btn, start, coin); end
    endtask

    task automatic test_keyboard;
        ps2_event(1'b1, 1'b1, 8'h74);
        step(1);
        checks++; if (dir !== 8'h00) begin fails++; $display("[TB] FAIL kb_latency1: got %h expected 00", dir); end
        step(1);
        checks++; if (dir !== 8'h01) begin fails++; $display("[TB] FAIL kb_right_press: got %h expected 01", dir); end
        ps2_event(1'b1, 1'b0, 8'h74);
        step(2);
        checks++; if (dir !== 8'h01) begin fails++; $display("[TB] FAIL kb_nonext_ignored: got %h expected 01", dir); end
        ps2_event(1'b0, 1'b1, 8'h74);
        step(2);
        checks++; if (dir !== 8'h00) begin fails++; $display("[TB] FAIL kb_right_release: got %h expected 00", dir); end
        ps2_event(1'b1, 1'b1, 8'h14);
        step(2);
        checks++; if (btn !== 4'h0) begin fails++; $display("[TB] FAIL kb_rctrl_not_btn: got %h expected 0", btn); end
        ps2_event(1'b1, 1'b0, 8'h14);
        step(2);
        checks++; if (btn !== 4'h1) begin fails++; $display("[TB] FAIL kb_lctrl_btn0: got %h expected 1", btn); end
        ps2_event(1'b0, 1'b0, 8'h14);
        step(2);
        checks++; if (btn !== 4'h0) begin fails++; $display("[TB] FAIL kb_lctrl_release: got %h expected 0", btn); end
        ps2_event(1'b1, 1'b0, 8'h2D);
        step(1);
        ps2_event(1'b1, 1'b0, 8'h16);
        step(2);
        checks++; if (dir !== 8'h80)  begin fails++; $display("[TB] FAIL kb_p2_up: got %h expected 80", dir); end
        checks++; if (start !== 2'b01) begin fails++; $display("[TB] FAIL kb_p1_start: got %b expected 01", start); end
        ps2_event(1'b0, 1'b0, 8'h2D);
        step(1);
        ps2_event(1'b0, 1'b0, 8'h16);
        step(2);
        checks++; if (dir !== 8'h00 || start !== 2'b00)
            begin fails++; $display("[TB] FAIL kb_release_all: got dir %h start %b expected 00 00", dir, start); end
    endtask

    task automatic test_src_sel;
        logic [1:0] sel_v     [4] = '{2'd0, 2'd1, 2'd2, 2'd3};
        logic [7:0] exp_dir   [4] = '{8'h10, 8'h00, 8'h00, 8'h10};
        logic [3:0] exp_btn   [4] = '{4'b0001, 4'b0110, 4'b0010, 4'b0011};
        logic [1:0] exp_start [4] = '{2'b00, 2'b00, 2'b10, 2'b10};
        joy_usb  = 32'h0001_0010;
        joy_db15 = 32'h0040_0020;
        for (int i = 0; i < 4; i++) begin
            src_sel = sel_v[i];
            step(1);
            checks++;
            if (dir !== exp_dir[i] || btn !== exp_btn[i] || start !== exp_start[i]) begin
                fails++;
                $display("[TB] FAIL src_sel_%0d: got dir %h btn %b start %b expected dir %h btn %b start %b",
                         i, dir, btn, start, exp_dir[i], exp_btn[i], exp_start[i]);
            end
        end
        joy_usb  = '0;
        joy_db15 = '0;
        src_sel  = 2'd0;
        step(2);
    endtask

    task automatic test_socd;
        logic [1:0]  mode_v [20] = '{2'd1, 2'd0, 2'd3, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
                                     2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1};
        logic [31:0] usb_v  [20] = '{32'h000C_0003, 32'h000C_0003, 32'h000C_0003, 32'h0000_0001,
                                     32'h0, 32'h1, 32'h1, 32'h1, 32'h3, 32'h3, 32'h1, 32'h0, 32'h3,
                                     32'h3, 32'h1, 32'h0008_0000, 32'h000C_0000, 32'h0004_0000,
                                     32'h000C_0000, 32'h0};
        logic [7:0]  exp_v  [20] = '{8'h00, 8'hC3, 8'hC3, 8'h01, 8'h00, 8'h01, 8'h01, 8'h01, 8'h02,
                                     8'h02, 8'h01, 8'h00, 8'h00, 8'h00, 8'h01, 8'h80, 8'h40, 8'h40,
                                     8'h80, 8'h00};
        for (int i = 0; i < 20; i++) begin
            socd_mode = mode_v[i];
            joy_usb   = usb_v[i];
            step(1);
            checks++;
            if (dir !== exp_v[i]) begin
                fails++;
                $display("[TB] FAIL socd_%0d: got dir %h expected %h", i, dir, exp_v[i]);
            end
        end
        socd_mode = 2'd0;
        joy_usb   = '0;
        step(2);
    endtask

    task automatic test_autofire;
        logic ph;
        autofire_en = 2'b01;
        joy_usb     = 32'h0000_0030;
        reset       = 1'b1;
        step(1);
        reset = 1'b0;
        for (int n = 1; n <= 32; n++) begin
            step(1);
            ph = ((n - 1) / 4) % 2 == 1;
            checks++;
            if (btn !== {2'b00, 1'b1, ph}) begin
                fails++;
                $display("[TB] FAIL autofire_cycle_%0d: got btn %b expected %b", n, btn, {2'b00, 1'b1, ph});
            end
        end
        autofire_en = 2'b00;
        joy_usb     = '0;
        step(2);
    endtask

    task automatic test_coin;
        logic expc;
        joy_usb = 32'h0000_0100;
        for (int n = 1; n <= 50; n++) begin
            step(1);
            expc = (n <= 10);
            checks++;
            if (coin !== {1'b0, expc}) begin
                fails++;
                $display("[TB] FAIL coin_held_%0d: got %b expected %b", n, coin, {1'b0, expc});
            end
        end
        joy_usb = '0;
        step(3);
        joy_usb = 32'h0000_0100;
        for (int n = 1; n <= 12; n++) begin
            step(1);
            expc = (n <= 10);
            checks++;
            if (coin !== {1'b0, expc}) begin
                fails++;
                $display("[TB] FAIL coin_repress_%0d: got %b expected %b", n, coin, {1'b0, expc});
            end
        end
        joy_usb = '0;
        step(2);
        joy_usb = 32'h0000_0100;
        step(5);
        checks++; if (coin !== 2'b01) begin fails++; $display("[TB] FAIL coin_mid_pulse: got %b expected 01", coin); end
        reset = 1'b1;
        step(1);
        checks++; if (coin !== 2'b00) begin fails++; $display("[TB] FAIL coin_reset_cut: got %b expected 00", coin); end
        reset = 1'b0;
        for (int n = 1; n <= 15; n++) begin
            step(1);
            checks++;
            if (coin !== 2'b00) begin
                fails++;
                $display("[TB] FAIL coin_held_after_reset_%0d: got %b expected 00", n, coin);
            end
        end
        joy_usb = '0;
        step(2);
        joy_usb = 32'h0000_0100;
        step(1);
        checks++; if (coin !== 2'b01) begin fails++; $display("[TB] FAIL coin_rearm: got %b expected 01", coin); end
        joy_usb = '0;
        step(12);
        checks++; if (coin !== 2'b00) begin fails++; $display("[TB] FAIL coin_rearm_end: got %b expected 00", coin); end
        ps2_event(1'b1, 1'b0, 8'h36);
        step(1);
        checks++; if (coin !== 2'b00) begin fails++; $display("[TB] FAIL coin_kb_latency1: got %b expected 00", coin); end
        step(1);
        checks++; if (coin !== 2'b10) begin fails++; $display("[TB] FAIL coin_kb_p2: got %b expected 10", coin); end
        ps2_event(1'b0, 1'b0, 8'h36);
        step(11);
        checks++; if (coin !== 2'b00) begin fails++; $display("[TB] FAIL coin_kb_p2_end: got %b expected 00", coin); end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_keyboard();
        test_src_sel();
        test_socd();
        test_autofire();
        test_coin();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
